banked_regfile: RTL and testbench

Parametrised multi-bank register file for the single-cycle CPU datapath. It replaces the fixed 16×16 two-read/one-write file and adds hardware register banks for interrupt and subroutine context switching. A bank-depth counter selects the active bank; push/pop commands switch context in one cycle without saving registers to memory. The block sits between instruction decode (register addresses, bank commands) and the ALU/writeback path.

---
 rtl/banked_regfile.sv | 112 +++++++++++
 tb/tb_banked_regfile.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_regfile.sv
// banked_regfile
// ---------------
// Multi-bank register file for the single-cycle CPU datapath. Each bank holds
// NREGS words of WIDTH bits. A bank-depth counter (cur_bank) picks the active
// bank. push/pop commands switch interrupt or subroutine context in one cycle
// without spilling registers to memory.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   we3, wa3, wd3       write port into the active bank
//   ra1 / rd1           read port 1, active bank, combinational
//   ra2, rsel2 / rd2    read port 2; rsel2 selects the previous bank
//   bank_push/bank_pop  enter / leave a context (depth +1 / -1)
//   clr_err             clears the sticky error flag
//   cur_bank            active bank index (equals the stack depth)
//   full, empty         depth at its maximum / at zero
//   err                 sticky flag: illegal push or pop was attempted
module banked_regfile #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 16,
    parameter int NBANKS  = 4,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit FWD     = 1'b0,
    localparam int AW     = $clog2(NREGS),
    localparam int BW     = $clog2(NBANKS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             rsel2,
    input  logic             bank_push,
    input  logic             bank_pop,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [BW-1:0]    cur_bank,
    output logic             full,
    output logic             empty,
    output logic             err
);

    logic [WIDTH-1:0] mem_q [NBANKS][NREGS];

    logic [BW-1:0] bank_q, bank_d;
    logic          err_q, err_d;
    logic          wr_en;
    logic          use_prev;
    logic [BW-1:0] bank2;

    assign cur_bank = bank_q;
    assign err      = err_q;
    assign full     = (bank_q == BW'(NBANKS - 1));
    assign empty    = (bank_q == '0);

    // A write to r0 is dropped when r0 is hard-wired to zero. This also keeps
    // the bypass from forwarding data that never reaches storage.
    assign wr_en = we3 && !(ZERO_R0 && (wa3 == '0));

    // Port 2 may look one context back. At depth 0 there is no previous bank,
    // so the request quietly falls back to the active bank.
    assign use_prev = rsel2 && !empty;
    assign bank2    = use_prev ? (bank_q - BW'(1)) : bank_q;

    // Bank stack. Push and pop together cancel out. The error flag is set
    // after the clear is applied, so a set in the same cycle wins.
    always_comb begin
        bank_d = bank_q;
        err_d  = clr_err ? 1'b0 : err_q;
        if (bank_push && !bank_pop) begin
            if (full) err_d  = 1'b1;
            else      bank_d = bank_q + BW'(1);
        end else if (bank_pop && !bank_push) begin
            if (empty) err_d  = 1'b1;
            else       bank_d = bank_q - BW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q <= '0;
            err_q  <= 1'b0;
        end else begin
            bank_q <= bank_d;
            err_q  <= err_d;
        end
    end

    // Storage has no reset. The write uses the bank that is active before the
    // edge, so a write coinciding with push/pop lands in the old context.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[bank_q][wa3] <= wd3;
    end

    // Zero register takes priority over the bypass, which takes priority over storage.
    always_comb begin
        rd1 = mem_q[bank_q][ra1];
        if (FWD && wr_en && (wa3 == ra1)) rd1 = wd3;
        if (ZERO_R0 && (ra1 == '0))       rd1 = '0;
    end

    // The bypass applies only when port 2 is reading the active bank.
    always_comb begin
        rd2 = mem_q[bank2][ra2];
        if (FWD && wr_en && !use_prev && (wa3 == ra2)) rd2 = wd3;
        if (ZERO_R0 && (ra2 == '0))                    rd2 = '0;
    end

endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile
// ------------------
// Bench for banked_regfile. Two instances share every input: one without
// write bypass and one with it. A behavioural model of the storage and the
// bank stack supplies the expected value of every output. A directed sequence
// with literal expectations pins the model. A randomized phase follows.
module tb_banked_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        we3;
    logic [3:0]  ra1, ra2, wa3;
    logic [15:0] wd3;
    logic        rsel2, bank_push, bank_pop, clr_err;

    logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic [1:0]  bank_a, bank_b;
    logic        full_a, full_b, empty_a, empty_b, err_a, err_b;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    // Behavioural model state
    logic [15:0] m_mem   [4][16];
    bit          m_valid [4][16];
    int          m_bank = 0;
    bit          m_err  = 1'b0;

    always #5 clk = ~clk;

    banked_regfile #(.FWD(1'b0)) dut_a (
        .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3),
        .wd3(wd3), .rsel2(rsel2), .bank_push(bank_push), .bank_pop(bank_pop),
        .clr_err(clr_err), .rd1(rd1_a), .rd2(rd2_a), .cur_bank(bank_a),
        .full(full_a), .empty(empty_a), .err(err_a)
    );

    banked_regfile #(.FWD(1'b1)) dut_b (
        .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3),
        .wd3(wd3), .rsel2(rsel2), .bank_push(bank_push), .bank_pop(bank_pop),
        .clr_err(clr_err), .rd1(rd1_b), .rd2(rd2_b), .cur_bank(bank_b),
        .full(full_b), .empty(empty_b), .err(err_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle's worth of inputs just after the rising edge.
    task automatic applyStimulus(input logic we_i, input logic [3:0] wa_i,
                                 input logic [15:0] wd_i, input logic [3:0] ra1_i,
                                 input logic [3:0] ra2_i, input logic rsel_i,
                                 input logic push_i, input logic pop_i,
                                 input logic clr_i);
        @(posedge clk);
        #1;
        we3 = we_i; wa3 = wa_i; wd3 = wd_i; ra1 = ra1_i; ra2 = ra2_i;
        rsel2 = rsel_i; bank_push = push_i; bank_pop = pop_i; clr_err = clr_i;
    endtask

    task automatic idle(input logic [3:0] ra1_i);
        applyStimulus(1'b0, 4'd0, 16'h0, ra1_i, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Model: expected read value for one port, plus whether it is defined.
    function automatic void modelRead(input logic [3:0] ra, input bit prev_req,
                                      input bit fwd, output logic [15:0] val,
                                      output bit known);
        bit prev;
        int b;
        prev = prev_req && (m_bank != 0);
        b    = prev ? m_bank - 1 : m_bank;
        if (ra == 4'd0) begin
            val = 16'h0; known = 1'b1;
        end else if (fwd && we3 && (wa3 == ra) && !prev) begin
            val = wd3; known = 1'b1;
        end else begin
            val = m_mem[b][ra]; known = m_valid[b][ra];
        end
    endfunction

    // Model update: write to the old bank, then move the stack.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_bank = 0;
            m_err  = 1'b0;
        end else begin
            if (we3 && wa3 != 4'd0) begin
                m_mem[m_bank][wa3]   = wd3;
                m_valid[m_bank][wa3] = 1'b1;
            end
            if (clr_err) m_err = 1'b0;
            if (bank_push && !bank_pop) begin
                if (m_bank == 3) m_err = 1'b1;
                else             m_bank = m_bank + 1;
            end else if (bank_pop && !bank_push) begin
                if (m_bank == 0) m_err = 1'b1;
                else             m_bank = m_bank - 1;
            end
        end
    end

    // Compare every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        logic [15:0] v;
        bit          k;
        if (cmp_on) begin
            checkOutput("cur_bank_a", 32'(bank_a), 32'(m_bank));
            checkOutput("cur_bank_b", 32'(bank_b), 32'(m_bank));
            checkOutput("err_a", 32'(err_a), 32'(m_err));
            checkOutput("err_b", 32'(err_b), 32'(m_err));
            checkOutput("full_a", 32'(full_a), 32'(m_bank == 3));
            checkOutput("full_b", 32'(full_b), 32'(m_bank == 3));
            checkOutput("empty_a", 32'(empty_a), 32'(m_bank == 0));
            checkOutput("empty_b", 32'(empty_b), 32'(m_bank == 0));
            modelRead(ra1, 1'b0, 1'b0, v, k);
            if (k) checkOutput("rd1_a", 32'(rd1_a), 32'(v));
            modelRead(ra1, 1'b0, 1'b1, v, k);
            if (k) checkOutput("rd1_b", 32'(rd1_b), 32'(v));
            modelRead(ra2, rsel2, 1'b0, v, k);
            if (k) checkOutput("rd2_a", 32'(rd2_a), 32'(v));
            modelRead(ra2, rsel2, 1'b1, v, k);
            if (k) checkOutput("rd2_b", 32'(rd2_b), 32'(v));
        end
    end

    initial begin
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 16; r++) m_valid[b][r] = 1'b0;
        reset = 1'b1;
        we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
        rsel2 = 1'b0; bank_push = 1'b0; bank_pop = 1'b0; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_bank", 32'(bank_a), 32'd0);
        checkOutput("reset_empty", 32'(empty_a), 32'd1);
        checkOutput("reset_full", 32'(full_a), 32'd0);
        checkOutput("reset_err", 32'(err_a), 32'd0);
        reset = 1'b0;
        cmp_on = 1'b1;

        // Write r5 in bank 0, then attempt a write to r0
        applyStimulus(1'b1, 4'd5, 16'h1234, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd0, 16'hFFFF, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lit_r5_bank0", 32'(rd1_a), 32'h1234);
        idle(4'd0);
        @(negedge clk);
        checkOutput("lit_r0_zero", 32'(rd1_a), 32'h0);

        // Push, write bank 1, read the previous bank through port 2
        applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd5, 16'hBEEF, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lit_r5_bank1", 32'(rd1_a), 32'hBEEF);
        checkOutput("lit_rsel2_prev", 32'(rd2_a), 32'h1234);
        checkOutput("lit_bank1", 32'(bank_a), 32'd1);
        applyStimulus(1'b0, 4'd0, 16'h0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4'd5);
        @(negedge clk);
        checkOutput("lit_pop_r5", 32'(rd1_a), 32'h1234);
        checkOutput("lit_pop_bank", 32'(bank_a), 32'd0);

        // Fill the stack, overflow, clear, drain, underflow
        repeat (3) applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4'd0);
        @(negedge clk);
        checkOutput("lit_full_bank", 32'(bank_a), 32'd3);
        checkOutput("lit_full", 32'(full_a), 32'd1);
        applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4'd0);
        @(negedge clk);
        checkOutput("lit_ovf_bank", 32'(bank_a), 32'd3);
        checkOutput("lit_ovf_err", 32'(err_a), 32'd1);
        applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4'd0);
        @(negedge clk);
        checkOutput("lit_clr_err", 32'(err_a), 32'd0);
        repeat (3) applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4'd0);
        @(negedge clk);
        checkOutput("lit_unf_bank", 32'(bank_a), 32'd0);
        checkOutput("lit_unf_err", 32'(err_a), 32'd1);
        applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Bypass versus no bypass
        applyStimulus(1'b1, 4'd7, 16'h1111, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd7, 16'hA5A5, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lit_fwd_on", 32'(rd1_b), 32'hA5A5);
        checkOutput("lit_fwd_off", 32'(rd1_a), 32'h1111);
        idle(4'd7);
        @(negedge clk);
        checkOutput("lit_fwd_off_after", 32'(rd1_a), 32'hA5A5);

        // Simultaneous push and pop with a write at depth 2
        repeat (2) applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd3, 16'h0042, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(4'd3);
        @(negedge clk);
        checkOutput("lit_pp_bank", 32'(bank_a), 32'd2);
        checkOutput("lit_pp_err", 32'(err_a), 32'd0);
        checkOutput("lit_pp_r3", 32'(rd1_a), 32'h0042);

        // Asynchronous reset in the middle of a cycle at depth 2 with err set
        applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4'd5);
        @(posedge clk);
        #2;
        checkOutput("lit_pre_rst_bank", 32'(bank_a), 32'd2);
        checkOutput("lit_pre_rst_err", 32'(err_a), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("lit_rst_bank", 32'(bank_a), 32'd0);
        checkOutput("lit_rst_err", 32'(err_a), 32'd0);
        checkOutput("lit_rst_empty", 32'(empty_b), 32'd1);
        checkOutput("lit_rst_keep_r5", 32'(rd1_a), 32'h1234);
        #2;
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
                          4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 7) == 0));
        end
        idle(4'd0);
        @(negedge clk);
        cmp_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
